// File: rtl/unified_mem_arbiter_pkg.sv
// Shared constants for the unified code/data memory arbiter:
// response-owner encodings, default sizes and the alignment helper.
package unified_mem_arbiter_pkg;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_IF   = 2'd1;
    localparam logic [1:0] RESP_MEM  = 2'd2;

    localparam int MAX_MEM_STREAK_DEF = 4;
    localparam int MEM_WORDS_LOG2_DEF = 17;

    localparam logic [31:0] ZERO_WORD = 32'h0;
    localparam logic        CHIP_ENA  = 1'b1;
    localparam logic        CHIP_DISA = 1'b0;
    localparam logic [3:0]  SEL_WORD  = 4'hF;

    // Word access needs addr[1:0]==0; half-word access needs addr[0]==0.
    function automatic logic misaligned(input logic [1:0] lo,
                                        input logic [3:0] sel);
        logic bad;
        bad = 1'b0;
        if (sel == SEL_WORD)
            bad = |lo;
        else if (sel == 4'b0011 || sel == 4'b1100)
            bad = lo[0];
        return bad;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_arb_prio2.sv
// Two-way fixed priority (hi wins) with a forced low-side grant
// once the high side has won MAX_STREAK times in a row.
// Ports: req_hi/req_lo requests, streak count, gnt_hi/gnt_lo grants.
module arb_prio2 #(
    parameter int MAX_STREAK = 4
) (
    input  logic       req_hi,
    input  logic       req_lo,
    input  logic [3:0] streak,
    output logic       gnt_hi,
    output logic       gnt_lo
);

    logic lo_forced;

    assign lo_forced = req_lo && (streak == 4'(MAX_STREAK));
    assign gnt_hi    = req_hi & ~lo_forced;
    assign gnt_lo    = req_lo & ~gnt_hi;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port sync-read RAM between IF (fetch)
// and MEM (load/store). MEM has priority; a streak counter forces
// IF through after MAX_MEM_STREAK consecutive MEM wins.
// Ports: if_* fetch port, mem_* data port, stallreq_* to ctrl,
// ram_* to the RAM macro (read data one cycle after ram_ce).
// Optional `ALIGN_CHECK_EN: misaligned accesses skip the RAM,
// answer with zero data and pulse if_adel / mem_ade.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int MAX_MEM_STREAK = MAX_MEM_STREAK_DEF,
    parameter int MEM_WORDS_LOG2 = MEM_WORDS_LOG2_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [31:0]               if_addr,
    output logic [31:0]               if_inst,
    output logic                      if_valid,
    input  logic                      mem_req,
    input  logic                      mem_we,
    input  logic [31:0]               mem_addr,
    input  logic [3:0]                mem_sel,
    input  logic [31:0]               mem_wdata,
    output logic [31:0]               mem_rdata,
    output logic                      mem_valid,
    output logic                      stallreq_if,
    output logic                      stallreq_mem,
`ifdef ALIGN_CHECK_EN
    output logic                      if_adel,
    output logic                      mem_ade,
`endif
    output logic                      ram_ce,
    output logic                      ram_we,
    output logic [MEM_WORDS_LOG2-1:0] ram_addr,
    output logic [3:0]                ram_sel,
    output logic [31:0]               ram_wdata,
    input  logic [31:0]               ram_rdata
);

    logic [1:0] resp_q;
    logic [3:0] streak_q;
    logic       store_q;
    logic       bad_q;
    logic       gnt_if;
    logic       gnt_mem;
    logic       if_bad;
    logic       mem_bad;
    logic       unused_bits;

    // A request raised in its own valid cycle is a new request,
    // so a high req always competes for the slot.
    arb_prio2 #(
        .MAX_STREAK(MAX_MEM_STREAK)
    ) u_prio (
        .req_hi (mem_req & ~rst),
        .req_lo (if_req & ~rst),
        .streak (streak_q),
        .gnt_hi (gnt_mem),
        .gnt_lo (gnt_if)
    );

`ifdef ALIGN_CHECK_EN
    assign if_bad  = misaligned(if_addr[1:0], SEL_WORD);
    assign mem_bad = misaligned(mem_addr[1:0], mem_sel);
`else
    assign if_bad  = 1'b0;
    assign mem_bad = 1'b0;
`endif

    assign unused_bits = ^{if_addr, mem_addr};

    always_comb begin
        ram_ce    = CHIP_DISA;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_sel   = 4'h0;
        ram_wdata = ZERO_WORD;
        if (gnt_mem && !mem_bad) begin
            ram_ce    = CHIP_ENA;
            ram_we    = mem_we;
            ram_addr  = mem_addr[MEM_WORDS_LOG2+1:2];
            ram_sel   = mem_sel;
            ram_wdata = mem_wdata;
        end else if (gnt_if && !if_bad) begin
            ram_ce    = CHIP_ENA;
            ram_addr  = if_addr[MEM_WORDS_LOG2+1:2];
            ram_sel   = SEL_WORD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q   <= RESP_NONE;
            streak_q <= 4'd0;
            store_q  <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            resp_q  <= gnt_mem ? RESP_MEM :
                       gnt_if  ? RESP_IF  : RESP_NONE;
            store_q <= gnt_mem & mem_we;
            bad_q   <= (gnt_mem & mem_bad) | (gnt_if & if_bad);
            if (gnt_if || !if_req)
                streak_q <= 4'd0;
            else if (gnt_mem && streak_q != 4'(MAX_MEM_STREAK))
                streak_q <= streak_q + 4'd1;
        end
    end

    // Outputs are forced quiet during reset so a response in
    // flight when reset hits is dropped.
    assign if_valid  = ~rst & (resp_q == RESP_IF);
    assign mem_valid = ~rst & (resp_q == RESP_MEM);
    assign if_inst   = (if_valid & ~bad_q) ? ram_rdata : ZERO_WORD;
    assign mem_rdata = (mem_valid & ~bad_q & ~store_q) ?
                       ram_rdata : ZERO_WORD;

    assign stallreq_if  = ~rst & if_req & ~if_valid;
    assign stallreq_mem = ~rst & mem_req & ~mem_valid;

`ifdef ALIGN_CHECK_EN
    assign if_adel = if_valid & bad_q;
    assign mem_ade = mem_valid & bad_q;
`endif

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, synchronous-read code/data memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sits between `pc_reg`/IF and `mem` on one side and the unified RAM macro on the other.
- Drives per-port stall requests into the pipeline `ctrl` block.
- Data port has priority; a streak counter guarantees fetch forward progress.

Parameters:
- MAX_MEM_STREAK, 4: maximum consecutive MEM grants while IF is waiting before IF is forced through; legal range 1..15.
- MEM_WORDS_LOG2, 17: log2 of memory depth in words; `ram_addr` = `addr[MEM_WORDS_LOG2+1:2]`.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with `if_addr` stable until `if_valid`
- if_addr  in  32  byte address of instruction
- if_inst  out  32  fetched instruction; valid only with `if_valid`
- if_valid  out  1  one-cycle response pulse
- mem_req  in  1  data request; held with its qualifiers stable until `mem_valid`
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  byte address
- mem_sel  in  4  byte enables
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data; valid only with `mem_valid`
- mem_valid  out  1  one-cycle response pulse (loads and stores)
- stallreq_if  out  1  `if_req & ~if_valid`
- stallreq_mem  out  1  `mem_req & ~mem_valid`
- ram_ce  out  1  memory enable, combinational grant strobe
- ram_we  out  1  memory write enable
- ram_addr  out  MEM_WORDS_LOG2  word address
- ram_sel  out  4  byte enables (4'hF for fetches)
- ram_wdata  out  32  write data
- ram_rdata  in  32  memory read data, one cycle after `ram_ce`

Behaviour:
- State register `resp` ∈ {NONE, IF, MEM}: the owner of the access issued last cycle.
- Reset: `resp`=NONE, streak=0, all outputs 0. A pending response is discarded.
- Grant (combinational, every cycle): requester = `req` high and not receiving its response this cycle, or receiving it and `req` still high.
  - `req` high in the cycle its valid is high is treated as a NEW request (back-to-back, 1 access/cycle).
- Priority:
  - MEM alone → MEM.
  - IF alone → IF.
  - Both → MEM, unless streak == MAX_MEM_STREAK, then IF.
- Streak counter:
  - +1 on each MEM grant while `if_req` is pending.
  - Cleared on IF grant or when `if_req` is low.
  - Saturates at MAX_MEM_STREAK.
- Granted cycle N:
  - `ram_ce`=1; `ram_addr`/`ram_sel`/`ram_we`/`ram_wdata` come from the winner.
  - IF: `ram_we`=0, `ram_sel`=4'hF.
  - `resp` ← owner.
- Cycle N+1:
  - Owner's valid=1.
  - `if_inst` or `mem_rdata` = `ram_rdata` (combinational pass-through).
  - Stores also pulse `mem_valid`; `mem_rdata`=0 for stores.
- No grant: `ram_ce`=0, all `ram_*`=0, `resp` ← NONE.
- Non-owner data outputs = 0 (`ZeroWord`).
- Latency: 1 cycle uncontended; worst-case IF wait = MAX_MEM_STREAK+1 cycles.
- Requester dropping `req` before its valid: response still issued and ignored (no cancel).

Optional Feature:
- ALIGN_CHECK_EN defined:
  - IF or MEM word access with `addr[1:0]` ≠ 0, or a half-word access with `addr[0]`, gets no RAM access.
  - Next cycle it returns valid with zero data and pulses extra outputs `if_adel` / `mem_ade` (1 bit each).
  - It still consumes an arbitration slot.
- Not defined: those ports are absent and the low address bits are ignored.

Decomposition:
- `define.v` gains:
  - `RespNone` / `RespIf` / `RespMem` encodings
  - `RamAddrBus`
  - `MaxMemStreak` default
- Existing `ZeroWord`, `ChipEna`/`ChipDisa`, `InstBus`, `InstAddrBus` are reused.
- One natural sub-module: `arb_prio2`, the pure combinational two-way priority plus streak compare, instantiated once.

Test Plan:
- Reset: assert `rst` with `if_req`=1 mid-access → next cycle `if_valid`=0, `ram_ce`=0, all outputs 0; first grant one cycle after `rst` deasserts.
- Fetch stream: `if_req` held, `if_addr` 0x0, 0x4, 0x8 updated on each valid; RAM word0..2 = 0x34011100, 0x34020020, 0x00411825 → `if_valid` every cycle after the first, `if_inst` in order, `stallreq_if`=1 only in cycle 0.
- Contention: `if_req` and `mem_req` (load 0x100) both rise in the same cycle → MEM granted first, `mem_valid` next cycle, IF granted that same cycle, `if_valid` one cycle later.
- Starvation: `mem_req` held continuously with `if_req`, MAX_MEM_STREAK=4 → exactly 4 MEM grants, then 1 IF grant, then MEM again; pattern repeats.
- Store: `mem_we`=1, `mem_sel`=4'b0011, addr 0x200, wdata 0xDEADBEEF → `ram_we`=1, `ram_sel`=4'b0011, `ram_addr`=0x80 in the grant cycle, `mem_valid`=1 with `mem_rdata`=0 next cycle.
- ALIGN_CHECK_EN: load addr 0x102 with `mem_sel`=4'hF → `ram_ce` stays 0; next cycle `mem_valid`=1, `mem_ade`=1, `mem_rdata`=0.
